// File: rtl/imem_loader.sv
// imem_loader: writer side of the RAM-based instruction memory.
// Collects a little-endian byte stream into N-bit words and writes them to
// consecutive imem addresses starting at 0. The processor is held in reset
// for the whole load.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte and drives err on a mismatch.
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [N-1:0]  wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int NB = N / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    WRITE
  } state_t;

  state_t        state;
  logic [BW-1:0] byte_idx;
  // Remaining word count; a count byte of 0 wraps to 2^AW words, and
  // decrementing from 0 reaches all-ones, so AW bits are enough.
  logic [AW-1:0] remaining;
  logic          xfer;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  // Handshake and write strobe depend only on the registered state, so
  // in_valid/in_data never reach in_ready or we combinationally.
  assign in_ready = (state == LEN) || (state == DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    || (state == CSUM)
`endif
                    ;
  assign we       = (state == WRITE);
  assign cpu_hold = (state != IDLE);
  assign xfer     = in_valid && in_ready;

`ifndef IMEM_LOADER_CHECKSUM_EN
  assign err = 1'b0;
`endif

  // Load sequencer: count byte, data bytes, one write cycle per word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      byte_idx  <= '0;
      remaining <= '0;
      waddr     <= '0;
      wdata     <= '0;
      done      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum  <= '0;
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done     <= 1'b0;
            waddr    <= '0;
            byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum <= '0;
            err      <= 1'b0;
`endif
            state    <= LEN;
          end
        end
        LEN: begin
          if (xfer) begin
            remaining <= in_data[AW-1:0];
            state     <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            wdata[{byte_idx, 3'b000} +: 8] <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum <= checksum ^ in_data;
`endif
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              state    <= WRITE;
            end else begin
              byte_idx <= byte_idx + BW'(1);
            end
          end
        end
        WRITE: begin
          waddr     <= waddr + AW'(1);
          remaining <= remaining - AW'(1);
          if (remaining != AW'(1)) begin
            state <= DATA;
          end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CSUM;
`else
            done  <= 1'b1;
            state <= IDLE;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer) begin
            err   <= (in_data != checksum);
            done  <= 1'b1;
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with hand-computed words.
// Works in both builds; checksum bytes are sent only when
// IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int N  = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int readyInWrite = 0;
  logic [7:0]    tbCsum;
  logic [AW-1:0] wrAddr[$];
  logic [N-1:0]  wrData[$];

  imem_loader #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Record every write pulse and flag any cycle that offers ready while writing.
  always @(negedge clk) begin
    if (we) begin
      wrAddr.push_back(waddr);
      wrData.push_back(wdata);
      if (in_ready) readyInWrite++;
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one byte after gap idle cycles; returns on the negedge after it transfers.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) checkOutput("handshake_timeout", 64'd1, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic sendDataByte(input logic [7:0] b, input int gap);
    tbCsum = tbCsum ^ b;
    applyStimulus(b, gap);
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) sendDataByte(w[8*i +: 8], gap);
  endtask

  task automatic startLoad();
    tbCsum = 8'h00;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {63'd0, done}, 64'd1);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_we", {63'd0, we}, 64'd0);
    checkOutput("rst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_err", {63'd0, err}, 64'd0);
    checkOutput("rst_waddr", 64'(waddr), 64'd0);
    checkOutput("rst_wdata", 64'(wdata), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single word, no stalls");
    startLoad();
    checkOutput("t1_hold_after_start", {63'd0, cpu_hold}, 64'd1);
    checkOutput("t1_ready_in_len", {63'd0, in_ready}, 64'd1);
    checkOutput("t1_done_low", {63'd0, done}, 64'd0);
    applyStimulus(8'h01, 0);
    sendWord(32'hF800_0001, 0);
    checkOutput("t1_we", {63'd0, we}, 64'd1);
    checkOutput("t1_waddr", 64'(waddr), 64'd0);
    checkOutput("t1_wdata", 64'(wdata), 64'hF800_0001);
    checkOutput("t1_ready_in_write", {63'd0, in_ready}, 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(tbCsum, 0);
    checkOutput("t1_err", {63'd0, err}, 64'd0);
`else
    @(negedge clk);
`endif
    checkOutput("t1_done", {63'd0, done}, 64'd1);
    checkOutput("t1_hold_released", {63'd0, cpu_hold}, 64'd0);
    checkOutput("t1_we_single", {63'd0, we}, 64'd0);
    checkOutput("t1_waddr_next", 64'(waddr), 64'd1);

    $display("[TB] three words with toggling valid");
    wrAddr.delete();
    wrData.delete();
    startLoad();
    checkOutput("t2_done_cleared", {63'd0, done}, 64'd0);
    checkOutput("t2_waddr_cleared", 64'(waddr), 64'd0);
    applyStimulus(8'h03, 1);
    sendWord(32'hF800_0001, 1);
    sendWord(32'hF800_8002, 1);
    sendWord(32'hF800_0203, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(tbCsum, 1);
`endif
    waitDone("t2_done");
    checkOutput("t2_count", 64'(wrAddr.size()), 64'd3);
    if (wrAddr.size() == 3) begin
      checkOutput("t2_addr0", 64'(wrAddr[0]), 64'd0);
      checkOutput("t2_data0", 64'(wrData[0]), 64'hF800_0001);
      checkOutput("t2_addr1", 64'(wrAddr[1]), 64'd1);
      checkOutput("t2_data1", 64'(wrData[1]), 64'hF800_8002);
      checkOutput("t2_addr2", 64'(wrAddr[2]), 64'd2);
      checkOutput("t2_data2", 64'(wrData[2]), 64'hF800_0203);
    end

    $display("[TB] count byte 0 loads 64 words");
    wrAddr.delete();
    wrData.delete();
    startLoad();
    applyStimulus(8'h00, 0);
    for (int i = 0; i < 64; i++) sendWord(32'(i), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(tbCsum, 0);
`endif
    waitDone("t3_done");
    checkOutput("t3_count", 64'(wrAddr.size()), 64'd64);
    if (wrAddr.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        checkOutput($sformatf("t3_addr%0d", i), 64'(wrAddr[i]), 64'(i));
        checkOutput($sformatf("t3_data%0d", i), 64'(wrData[i]), 64'(i));
      end
    end
    checkOutput("t3_waddr_wrapped", 64'(waddr), 64'd0);

    $display("[TB] reset mid-load then fresh load");
    startLoad();
    applyStimulus(8'h04, 0);
    sendWord(32'h1122_3344, 0);
    sendWord(32'h5566_7788, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("t4_rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("t4_rst_we", {63'd0, we}, 64'd0);
    checkOutput("t4_rst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    checkOutput("t4_rst_done", {63'd0, done}, 64'd0);
    checkOutput("t4_rst_err", {63'd0, err}, 64'd0);
    checkOutput("t4_rst_waddr", 64'(waddr), 64'd0);
    checkOutput("t4_rst_wdata", 64'(wdata), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wrAddr.delete();
    wrData.delete();
    startLoad();
    applyStimulus(8'h01, 0);
    sendDataByte(8'h34, 0);
    sendDataByte(8'h12, 0);
    start = 1'b1;
    sendDataByte(8'hA5, 0);
    start = 1'b0;
    sendDataByte(8'hA5, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(tbCsum, 0);
`endif
    waitDone("t4_done");
    checkOutput("t4_count", 64'(wrAddr.size()), 64'd1);
    if (wrAddr.size() == 1) begin
      checkOutput("t4_addr", 64'(wrAddr[0]), 64'd0);
      checkOutput("t4_data", 64'(wrData[0]), 64'hA5A5_1234);
    end
    checkOutput("t4_hold_released", {63'd0, cpu_hold}, 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    startLoad();
    applyStimulus(8'h01, 0);
    sendWord(32'h0403_0201, 0);
    applyStimulus(8'h04, 0);
    waitDone("t5_done_good");
    checkOutput("t5_err_good", {63'd0, err}, 64'd0);
    startLoad();
    applyStimulus(8'h01, 0);
    sendWord(32'h0403_0201, 0);
    applyStimulus(8'h05, 0);
    waitDone("t5_done_bad");
    checkOutput("t5_err_bad", {63'd0, err}, 64'd1);
`endif

    checkOutput("ready_during_write", 64'(readyInWrite), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
